// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: control-bundle layout
// and forwarding-select encodings.
package riscv_pipe_pkg;

    localparam int CTRL_W = 8;

    // Bit positions inside the control bundle carried down the pipe
    localparam int CTRL_REG_WRITE  = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_ALU_OP     = 0;

    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding operand selector: picks the registered value or one of the
// two later-stage bypass sources.
module fwd_mux
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] reg_val,
    input  logic [XLEN-1:0] ex_mem_val,
    input  logic [XLEN-1:0] mem_wb_val,
    output logic [XLEN-1:0] result
);

    // Encoding 2'b11 is unused by the forwarding unit and falls back to reg_val
    always_comb begin
        result = reg_val;
        case (sel)
            FWD_EX_MEM: result = ex_mem_val;
            FWD_MEM_WB: result = mem_wb_val;
            default:    result = reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded state, applies forwarding to
// produce EX operands, and inserts bubbles on flush or load-use hazards.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [1:0]        ForwardA,
    input  logic [1:0]        ForwardB,
    input  logic [XLEN-1:0]   ex_mem_alu_result,
    input  logic [XLEN-1:0]   mem_wb_wdata,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [XLEN-1:0]   ex_store_data,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic            insert_bubble;

    // rs2 is compared even when the ID instruction does not read it
    assign load_use_stall = ex_valid & ex_ctrl[CTRL_MEM_READ] & (ex_rd != 5'd0) & id_valid &
                            ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign insert_bubble = flush | load_use_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            bubble_cnt  <= '0;
        end else if (!hold) begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            // Zeroed indices keep a bubble invisible to forwarding and hazard logic
            if (insert_bubble) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
                ex_rs1   <= '0;
                ex_rs2   <= '0;
                ex_rd    <= '0;
                if (bubble_cnt != '1) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
            end else begin
                ex_valid <= id_valid;
                ex_ctrl  <= id_valid ? id_ctrl : '0;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
                ex_rd    <= id_rd;
            end
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .sel        (ForwardA),
        .reg_val    (ex_rs1_data),
        .ex_mem_val (ex_mem_alu_result),
        .mem_wb_val (mem_wb_wdata),
        .result     (ex_op_a)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .sel        (ForwardB),
        .reg_val    (ex_rs2_data),
        .ex_mem_val (ex_mem_alu_result),
        .mem_wb_val (mem_wb_wdata),
        .result     (ex_store_data)
    );

    assign ex_op_b = ex_ctrl[CTRL_ALU_SRC] ? ex_imm : ex_store_data;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table-driven load/forwarding vectors
// plus directed sequences for reset, load-use, hold/flush and saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [7:0]  id_ctrl;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] mem_wb_wdata;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_store_data;
    logic        load_use_stall;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic [31:0] exm;
        logic [31:0] mwb;
        logic        exp_valid;
        logic [7:0]  exp_ctrl;
        logic [4:0]  exp_rd;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_st;
    } vec_t;

    vec_t vecs[6];

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .hold              (hold),
        .flush             (flush),
        .id_valid          (id_valid),
        .id_pc             (id_pc),
        .id_rs1_data       (id_rs1_data),
        .id_rs2_data       (id_rs2_data),
        .id_imm            (id_imm),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_rd             (id_rd),
        .id_ctrl           (id_ctrl),
        .ForwardA          (ForwardA),
        .ForwardB          (ForwardB),
        .ex_mem_alu_result (ex_mem_alu_result),
        .mem_wb_wdata      (mem_wb_wdata),
        .ex_valid          (ex_valid),
        .ex_pc             (ex_pc),
        .ex_rs1            (ex_rs1),
        .ex_rs2            (ex_rs2),
        .ex_rd             (ex_rd),
        .ex_ctrl           (ex_ctrl),
        .ex_op_a           (ex_op_a),
        .ex_op_b           (ex_op_b),
        .ex_store_data     (ex_store_data),
        .load_use_stall    (load_use_stall),
        .bubble_cnt        (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        id_valid          = v.valid;
        id_pc             = v.pc;
        id_rs1_data       = v.rs1_data;
        id_rs2_data       = v.rs2_data;
        id_imm            = v.imm;
        id_rs1            = v.rs1;
        id_rs2            = v.rs2;
        id_rd             = v.rd;
        id_ctrl           = v.ctrl;
        ForwardA          = v.fwd_a;
        ForwardB          = v.fwd_b;
        ex_mem_alu_result = v.exm;
        mem_wb_wdata      = v.mwb;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic driveId(input logic valid, input logic [31:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl);
        id_valid = valid;
        id_pc    = pc;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_ctrl  = ctrl;
    endtask

    initial begin
        // valid pc rs1d rs2d imm rs1 rs2 rd ctrl fa fb exm mwb | valid ctrl rd a b st
        vecs[0] = '{1'b1, 32'h100, 32'h5, 32'h9, 32'h7, 5'd1, 5'd2, 5'd3, 8'h84, 2'b00, 2'b00, 32'hAA, 32'hBB,
                    1'b1, 8'h84, 5'd3, 32'h5, 32'h7, 32'h9};
        vecs[1] = '{1'b1, 32'h104, 32'h1, 32'h2, 32'h3, 5'd4, 5'd6, 5'd7, 8'h80, 2'b10, 2'b10, 32'hAA, 32'hBB,
                    1'b1, 8'h80, 5'd7, 32'hAA, 32'hAA, 32'hAA};
        vecs[2] = '{1'b1, 32'h108, 32'h1, 32'h2, 32'h3, 5'd4, 5'd6, 5'd8, 8'h80, 2'b01, 2'b01, 32'hAA, 32'hBB,
                    1'b1, 8'h80, 5'd8, 32'hBB, 32'hBB, 32'hBB};
        vecs[3] = '{1'b1, 32'h10C, 32'h1, 32'h2, 32'h3, 5'd4, 5'd6, 5'd9, 8'h80, 2'b11, 2'b11, 32'hAA, 32'hBB,
                    1'b1, 8'h80, 5'd9, 32'h1, 32'h2, 32'h2};
        vecs[4] = '{1'b1, 32'h110, 32'h1, 32'h2, 32'h3, 5'd4, 5'd6, 5'd10, 8'h84, 2'b11, 2'b00, 32'hAA, 32'hBB,
                    1'b1, 8'h84, 5'd10, 32'h1, 32'h3, 32'h2};
        vecs[5] = '{1'b0, 32'h114, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd5, 8'hFF, 2'b00, 2'b00, 32'hAA, 32'hBB,
                    1'b0, 8'h00, 5'd5, 32'h11, 32'h22, 32'h22};

        rst = 1'b1;
        hold = 1'b0;
        flush = 1'b0;
        applyStimulus('{1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 8'hFF, 2'b00, 2'b00, 32'h0, 32'h0,
                        1'b0, 8'h00, 5'd0, 32'h0, 32'h0, 32'h0});
        stepClock();
        stepClock();
        checkOutput("reset_valid", 32'(ex_valid), 32'h0);
        checkOutput("reset_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("reset_bubble_cnt", 32'(bubble_cnt), 32'h0);
        checkOutput("reset_stall", 32'(load_use_stall), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            stepClock();
            checkOutput($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
            checkOutput($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("v%0d_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].exp_ctrl));
            checkOutput($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].exp_rd));
            checkOutput($sformatf("v%0d_rs1", i), 32'(ex_rs1), 32'(vecs[i].rs1));
            checkOutput($sformatf("v%0d_op_a", i), ex_op_a, vecs[i].exp_a);
            checkOutput($sformatf("v%0d_op_b", i), ex_op_b, vecs[i].exp_b);
            checkOutput($sformatf("v%0d_store", i), ex_store_data, vecs[i].exp_st);
        end
        checkOutput("invalid_not_counted", 32'(bubble_cnt), 32'h0);

        // Load-use on rs2: lw x5 in EX, add reading x5 in ID
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        driveId(1'b1, 32'h200, 5'd1, 5'd0, 5'd5, 8'hE4);
        stepClock();
        driveId(1'b1, 32'h204, 5'd1, 5'd5, 5'd6, 8'h80);
        #1;
        checkOutput("lu_stall", 32'(load_use_stall), 32'h1);
        stepClock();
        checkOutput("lu_bubble_valid", 32'(ex_valid), 32'h0);
        checkOutput("lu_bubble_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("lu_bubble_rd", 32'(ex_rd), 32'h0);
        checkOutput("lu_bubble_cnt", 32'(bubble_cnt), 32'h1);
        checkOutput("lu_stall_cleared", 32'(load_use_stall), 32'h0);
        stepClock();
        checkOutput("lu_after_valid", 32'(ex_valid), 32'h1);
        checkOutput("lu_after_pc", ex_pc, 32'h204);

        // Load to x0 never stalls
        driveId(1'b1, 32'h300, 5'd1, 5'd0, 5'd0, 8'hE4);
        stepClock();
        driveId(1'b1, 32'h304, 5'd0, 5'd0, 5'd6, 8'h80);
        #1;
        checkOutput("x0_no_stall", 32'(load_use_stall), 32'h0);
        stepClock();
        checkOutput("x0_valid", 32'(ex_valid), 32'h1);
        checkOutput("x0_cnt", 32'(bubble_cnt), 32'h1);

        // Flush coinciding with a load-use stall counts once
        driveId(1'b1, 32'h400, 5'd1, 5'd0, 5'd7, 8'hE4);
        stepClock();
        driveId(1'b1, 32'h404, 5'd7, 5'd2, 5'd8, 8'h80);
        flush = 1'b1;
        #1;
        checkOutput("dual_stall", 32'(load_use_stall), 32'h1);
        stepClock();
        flush = 1'b0;
        checkOutput("dual_valid", 32'(ex_valid), 32'h0);
        checkOutput("dual_cnt", 32'(bubble_cnt), 32'h2);

        // Hold dominates flush
        driveId(1'b1, 32'h500, 5'd1, 5'd2, 5'd9, 8'h80);
        stepClock();
        driveId(1'b1, 32'h504, 5'd3, 5'd4, 5'd10, 8'h84);
        hold = 1'b1;
        flush = 1'b1;
        stepClock();
        checkOutput("hold_pc", ex_pc, 32'h500);
        checkOutput("hold_valid", 32'(ex_valid), 32'h1);
        checkOutput("hold_rd", 32'(ex_rd), 32'h9);
        checkOutput("hold_cnt", 32'(bubble_cnt), 32'h2);
        hold = 1'b0;
        stepClock();
        checkOutput("unhold_valid", 32'(ex_valid), 32'h0);
        checkOutput("unhold_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("unhold_cnt", 32'(bubble_cnt), 32'h3);

        // Saturate the bubble counter with repeated flushes
        for (int i = 0; i < 65532; i++) begin
            stepClock();
        end
        checkOutput("sat_reach", 32'(bubble_cnt), 32'hFFFF);
        stepClock();
        checkOutput("sat_hold", 32'(bubble_cnt), 32'hFFFF);
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        flush = 1'b0;
        checkOutput("sat_reset_cnt", 32'(bubble_cnt), 32'h0);
        checkOutput("sat_reset_valid", 32'(ex_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
